// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM
// read port, applies stall and branch redirect, and presents ID with an
// instruction word that stays stable while ID is stalled.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_WD = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_WD-1:0] stall,
  input  logic [32:0]         br_bus,
  output logic [32:0]         if_to_id_bus,
  output logic                inst_sram_en,
  output logic [3:0]          inst_sram_wen,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  input  logic [31:0]         inst_sram_rdata,
  output logic [31:0]         if_inst
);

  logic        br_e;
  logic [31:0] br_addr;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] next_pc;

  // Only the PC/IF and ID stop flags matter here; later stages are ignored.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_WD-1:2];

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Fetch address: a redirect parked during a stall wins over a live branch,
  // which wins over sequential fetch (32-bit wrap is intended).
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (pend_v_q) begin
      next_pc = pend_addr_q;
    end else if (br_e) begin
      next_pc = br_addr;
    end
  end

  // Next-state for PC, pending redirect and the ID-stall instruction hold buffer.
  always_comb begin
    pc_d        = pc_q;
    ce_d        = ce_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;

    if (stall[0]) begin
      // Front end frozen: remember only the first redirect seen while stopped.
      if (br_e && !pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_addr_d = br_addr;
      end
    end else begin
      pc_d     = next_pc;
      ce_d     = 1'b1;
      pend_v_d = 1'b0;
    end

    // Capture the word ID is looking at when it stalls, because the SRAM
    // output may move on underneath it.
    if (!stall[1]) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q && ce_q) begin
      hold_v_d = 1'b1;
      hold_d   = inst_sram_rdata;
    end
  end

  // Control and PC state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC - 32'd4;
      ce_q     <= 1'b0;
      pend_v_q <= 1'b0;
      hold_v_q <= 1'b0;
      hold_q   <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      ce_q     <= ce_d;
      pend_v_q <= pend_v_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

  // Pending redirect address is qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_en    = ~rst & ~stall[0];
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wdata = 32'h0;
  assign if_inst         = hold_v_q ? hold_q : inst_sram_rdata;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the fetch stage kept in the bench.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] if_inst;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_known = 0;
  logic [31:0] m_pc;
  bit          m_ce;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_hold;
  logic [31:0] m_hold_word;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'hBFC0_0000), .STALL_WD(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .if_inst(if_inst)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_addr();
    if (m_pend) return m_pend_addr;
    if (br_bus[32]) return br_bus[31:0];
    return m_pc + 32'd4;
  endfunction

  // Drive one cycle's inputs, let them settle, compare against the model.
  task automatic apply(input logic r, input logic [5:0] s, input logic [32:0] b, input logic [31:0] d);
    rst = r; stall = s; br_bus = b; inst_sram_rdata = d;
    #1;
    if (m_known) begin
      chk("bus",   {31'b0, if_to_id_bus}, {31'b0, m_ce, m_pc});
      chk("en",    {63'b0, inst_sram_en}, {63'b0, !r && !s[0]});
      chk("addr",  {32'b0, inst_sram_addr}, {32'b0, model_addr()});
      chk("inst",  {32'b0, if_inst}, {32'b0, m_hold ? m_hold_word : d});
      chk("wen",   {60'b0, inst_sram_wen}, 64'h0);
      chk("wdata", {32'b0, inst_sram_wdata}, 64'h0);
    end
  endtask

  // Clock edge: advance the model using the inputs that were present before it.
  task automatic step();
    logic [31:0] a;
    bit ce_old, hold_old;
    a = model_addr();
    ce_old = m_ce;
    hold_old = m_hold;
    @(posedge clk);
    #1;
    if (rst) begin
      m_known = 1; m_pc = 32'hBFBF_FFFC; m_ce = 0; m_pend = 0; m_hold = 0; m_hold_word = 0;
    end else begin
      if (!stall[0]) begin
        m_pc = a; m_ce = 1; m_pend = 0;
      end else if (br_bus[32] && !m_pend) begin
        m_pend = 1; m_pend_addr = br_bus[31:0];
      end
      if (!stall[1]) m_hold = 0;
      else if (!hold_old && ce_old) begin
        m_hold = 1; m_hold_word = inst_sram_rdata;
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    rst = 1; stall = 0; br_bus = 0; inst_sram_rdata = 0;
    @(posedge clk); #1;

    // 1: reset then sequential fetch
    repeat (3) begin apply(1, 6'b0, 33'b0, 32'h0); step(); end
    chk("rst_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    chk("rst_inst", {32'b0, if_inst}, 64'h0);
    apply(0, 6'b0, 33'b0, 32'h1111_0000);
    chk("t1_addr0", {32'b0, inst_sram_addr}, 64'hBFC0_0000);
    step();
    apply(0, 6'b0, 33'b0, 32'h1111_0001);
    chk("t1_addr1", {32'b0, inst_sram_addr}, 64'hBFC0_0004);
    chk("t1_bus1", {31'b0, if_to_id_bus}, {31'b0, 1'b1, 32'hBFC0_0000});
    step();
    apply(0, 6'b0, 33'b0, 32'h1111_0002);
    chk("t1_addr2", {32'b0, inst_sram_addr}, 64'hBFC0_0008);
    step();
    repeat (2) begin apply(0, 6'b0, 33'b0, $urandom); step(); end
    chk("t2_pc0", {32'b0, if_to_id_bus[31:0]}, 64'hBFC0_0010);

    // 2: redirect
    apply(0, 6'b0, {1'b1, 32'hBFC0_0100}, $urandom);
    step();
    chk("t2_pc1", {31'b0, if_to_id_bus}, {31'b0, 1'b1, 32'hBFC0_0100});
    apply(0, 6'b0, 33'b0, $urandom);
    step();
    chk("t2_pc2", {32'b0, if_to_id_bus[31:0]}, 64'hBFC0_0104);

    // 3: ID + IF stall with hold buffer
    apply(0, 6'b11, 33'b0, 32'h3C01_1234);
    chk("t3_inst0", {32'b0, if_inst}, 64'h3C01_1234);
    step();
    repeat (2) begin
      apply(0, 6'b11, 33'b0, 32'hDEAD_BEEF);
      chk("t3_hold", {32'b0, if_inst}, 64'h3C01_1234);
      chk("t3_pc", {32'b0, if_to_id_bus[31:0]}, 64'hBFC0_0104);
      step();
    end
    apply(0, 6'b0, 33'b0, 32'hCAFE_F00D);
    step();
    apply(0, 6'b0, 33'b0, 32'h1234_5678);
    chk("t3_track", {32'b0, if_inst}, 64'h1234_5678);
    step();

    // 4: redirect during front-end stall is parked then taken
    apply(0, 6'b01, {1'b1, 32'hBFC0_0200}, $urandom); step();
    repeat (2) begin apply(0, 6'b01, 33'b0, $urandom); step(); end
    apply(0, 6'b0, 33'b0, $urandom);
    chk("t4_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0200);
    step();
    apply(0, 6'b0, 33'b0, $urandom);
    chk("t4_clear", {32'b0, inst_sram_addr}, 64'hBFC0_0204);
    step();

    // 5: second redirect while one is pending is ignored
    apply(0, 6'b01, {1'b1, 32'hBFC0_0400}, $urandom); step();
    apply(0, 6'b01, {1'b1, 32'hBFC0_0300}, $urandom); step();
    apply(0, 6'b0, 33'b0, $urandom);
    chk("t5_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0400);
    step();

    // 6: reset while pending and holding
    apply(0, 6'b11, {1'b1, 32'hBFC0_0800}, 32'hAAAA_5555); step();
    apply(1, 6'b11, 33'b0, 32'h5555_AAAA); step();
    apply(0, 6'b0, 33'b0, 32'h0F0F_0F0F);
    chk("t6_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    chk("t6_inst", {32'b0, if_inst}, 64'h0F0F_0F0F);
    chk("t6_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0000);
    step();

    // 7: PC wrap
    apply(0, 6'b0, {1'b1, 32'hFFFF_FFFC}, $urandom); step();
    apply(0, 6'b0, 33'b0, $urandom);
    chk("t7_addr", {32'b0, inst_sram_addr}, 64'h0);
    step();
    chk("t7_pc", {32'b0, if_to_id_bus[31:0]}, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      logic [32:0] b;
      s = 6'($urandom);
      s[0] = ($urandom_range(0, 2) == 0);
      s[1] = ($urandom_range(0, 2) == 0);
      r = $urandom;
      b = {($urandom_range(0, 3) == 0), r[31:2], 2'b00};
      apply(($urandom_range(0, 40) == 0), s, b, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
